// File: rtl/clint_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CLINT bus port.
// Out-of-window or unanswered accesses complete with an error response.
module clint_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        s_en,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [7:0] TMO   = 8'(TIMEOUT);

    logic [1:0]  state;
    logic        last;
    logic        gnt;
    logic [7:0]  cnt;

    logic        win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [31:0] offset;
    logic        in_win;
    logic        tmo_hit;

    always_comb begin
        win       = (m0_req && m1_req) ? ~last : m1_req;
        win_we    = win ? m1_we : m0_we;
        win_addr  = win ? m1_addr : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
        // Unsigned offset wraps high for addresses below the base.
        offset    = win_addr - BASE_ADDR;
        in_win    = (offset[31:16] == 16'h0);
        tmo_hit   = ((cnt + 8'd1) == TMO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            gnt      <= 1'b0;
            cnt      <= 8'd0;
            s_en     <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= 32'h0;
            s_wdata  <= 32'h0;
            busy     <= 1'b0;
            m0_ready <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_ready <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'h0;
        end else begin
            s_en     <= 1'b0;
            m0_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_ready <= 1'b0;
            m1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt     <= win;
                        s_we    <= win_we;
                        s_addr  <= win_addr;
                        s_wdata <= win_wdata;
                        busy    <= 1'b1;
                        if (in_win) begin
                            state <= ISSUE;
                            s_en  <= 1'b1;
                        end else begin
                            state <= DONE;
                            last  <= win;
                            if (win) begin
                                m1_ready <= 1'b1;
                                m1_err   <= 1'b1;
                                m1_rdata <= 32'h0;
                            end else begin
                                m0_ready <= 1'b1;
                                m0_err   <= 1'b1;
                                m0_rdata <= 32'h0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= 8'd0;
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still wins.
                    if (s_ready || tmo_hit) begin
                        state <= DONE;
                        last  <= gnt;
                        if (gnt) begin
                            m1_ready <= 1'b1;
                            m1_err   <= ~s_ready;
                            m1_rdata <= s_ready ? s_rdata : 32'h0;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_err   <= ~s_ready;
                            m0_rdata <= s_ready ? s_rdata : 32'h0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed bench for clint_bus_arbiter with a cycle-level reference model
// and a responding CLINT stand-in.
module tb_clint_bus_arbiter;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          TMO  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ready, m0_err, m1_ready, m1_err, s_en, s_we, busy;
    logic [31:0] s_rdata = 0;
    logic        s_ready = 0;

    always #5 clk = ~clk;

    clint_bus_arbiter #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_ready(m1_ready), .m1_err(m1_err),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: transaction timeline in absolute edge numbers.
    bit          m_active;
    int          m_g, m_last, m_E, m_done, m_free;
    logic        e_en, e_busy, e_we;
    logic [1:0]  e_rdy, e_err;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;

    // CLINT stand-in and master behaviour
    int          sl_lat = 3;
    int          sl_cd = 0;
    logic [31:0] sl_data = 0;
    bit          drop0 = 1, drop1 = 1;

    // Observations taken from the DUT for the literal checks
    int          en_cnt = 0, en_cyc = 0, r0_cnt = 0, r1_cnt = 0;
    int          r0_cyc = 0, r1_cyc = 0;
    logic        r0_err, r1_err;
    logic [31:0] r0_rd, r1_rd;
    logic [31:0] wd_q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_g = 0; m_last = 1;
        m_E = -100; m_done = -100; m_free = 0;
        e_en = 0; e_busy = 0; e_we = 0; e_rdy = 0; e_err = 0;
        e_addr = 0; e_wd = 0; e_rd0 = 0; e_rd1 = 0;
    endtask

    task automatic complete(logic err, logic [31:0] data);
        m_done = cyc;
        m_last = m_g;
        m_free = cyc + 2;
        m_active = 0;
        e_rdy[m_g] = 1'b1;
        e_err[m_g] = err;
        if (m_g == 0) e_rd0 = data;
        else e_rd1 = data;
    endtask

    task automatic model_step();
        e_en = 0; e_rdy = 0; e_err = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_active && cyc >= m_free && (m0_req || m1_req)) begin
            if (m0_req && m1_req) m_g = 1 - m_last;
            else m_g = m1_req ? 1 : 0;
            e_we   = m_g ? m1_we : m0_we;
            e_addr = m_g ? m1_addr : m0_addr;
            e_wd   = m_g ? m1_wdata : m0_wdata;
            m_E = cyc;
            m_active = 1;
            if (e_addr >= BASE && e_addr < BASE + 32'h10000) e_en = 1;
            else complete(1'b1, 32'h0);
        end else if (m_active && cyc >= m_E + 2) begin
            if (s_ready) complete(1'b0, s_rdata);
            else if (cyc == m_E + 1 + TMO) complete(1'b1, 32'h0);
        end
        e_busy = m_active || (cyc == m_done);
    endtask

    task automatic check_all();
        chk("s_en", s_en, e_en);
        chk("busy", busy, e_busy);
        chk("m0_ready", m0_ready, e_rdy[0]);
        chk("m1_ready", m1_ready, e_rdy[1]);
        chk("m0_err", m0_err, e_err[0]);
        chk("m1_err", m1_err, e_err[1]);
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m1_rdata", m1_rdata, e_rd1);
        chk("s_we", s_we, e_we);
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wd);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_all();
        if (s_en) begin
            en_cnt++; en_cyc = cyc; wd_q.push_back(s_wdata);
        end
        if (m0_ready) begin
            r0_cnt++; r0_cyc = cyc; r0_err = m0_err; r0_rd = m0_rdata;
            if (drop0) m0_req = 0;
        end
        if (m1_ready) begin
            r1_cnt++; r1_cyc = cyc; r1_err = m1_err; r1_rd = m1_rdata;
            if (drop1) m1_req = 0;
        end
        if (sl_cd > 0) begin
            sl_cd--;
            s_ready = (sl_cd == 0);
        end else begin
            s_ready = 0;
        end
        if (s_en && sl_lat >= 0) sl_cd = sl_lat;
        s_rdata = sl_data;
    endtask

    task automatic wait_rdy(int which, int budget);
        int n = 0;
        int c0 = r0_cnt;
        int c1 = r1_cnt;
        while (((which == 0) ? (r0_cnt == c0) : (r1_cnt == c1)) && n < budget) begin
            tick();
            n++;
        end
        if (n == budget) chk("ready_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        m0_req = 0; m1_req = 0;
        sl_cd = 0; s_ready = 0;
        model_reset();
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        int c0, e0, q0;
        model_reset();
        // Reset state
        @(negedge clk);
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_m0_rdata", m0_rdata, 32'h0);
        chk("reset_s_addr", s_addr, 32'h0);
        rst_n = 1;
        tick();

        // Single read
        sl_lat = 3; sl_data = 32'h0000_0123;
        e0 = en_cnt;
        m0_we = 0; m0_addr = 32'h0200_BFF8; m0_req = 1;
        wait_rdy(0, 20);
        chk("read_en_pulses", en_cnt - e0, 1);
        chk("read_latency", r0_cyc - en_cyc, 4);
        chk("read_rdata", r0_rd, 32'h0000_0123);
        chk("read_err", r0_err, 1'b0);
        repeat (3) tick();

        // Tie from reset
        do_reset();
        sl_data = 32'h5555_AAAA;
        e0 = en_cnt; q0 = wd_q.size();
        m0_we = 1; m0_addr = 32'h0200_4000; m0_wdata = 32'hAAAA_0000;
        m1_we = 1; m1_addr = 32'h0200_4000; m1_wdata = 32'hBBBB_1111;
        m0_req = 1; m1_req = 1;
        wait_rdy(1, 40);
        chk("tie_en_pulses", en_cnt - e0, 2);
        chk("tie_first_wdata", wd_q[q0], 32'hAAAA_0000);
        chk("tie_second_wdata", wd_q[q0+1], 32'hBBBB_1111);
        chk("tie_order", r0_cyc < r1_cyc, 1);
        repeat (3) tick();

        // Out of range
        e0 = en_cnt; c0 = cyc;
        m1_we = 0; m1_addr = 32'h1000_0000; m1_req = 1;
        wait_rdy(1, 10);
        chk("oor_no_en", en_cnt - e0, 0);
        chk("oor_err", r1_err, 1'b1);
        chk("oor_rdata", r1_rd, 32'h0);
        chk("oor_latency", r1_cyc - c0, 1);
        repeat (3) tick();

        // Timeout, then stray ready in DONE and IDLE
        sl_lat = -1;
        m0_we = 0; m0_addr = 32'h0200_0000; m0_req = 1;
        wait_rdy(0, 20);
        chk("tmo_latency", r0_cyc - en_cyc, 5);
        chk("tmo_err", r0_err, 1'b1);
        chk("tmo_rdata", r0_rd, 32'h0);
        c0 = r0_cnt;
        s_ready = 1; tick();
        s_ready = 1; tick();
        tick();
        chk("tmo_stray_ignored", r0_cnt - c0, 0);
        chk("tmo_busy_low", busy, 1'b0);

        // Reset in the middle of WAIT
        m0_req = 1;
        repeat (3) tick();
        chk("mid_busy_before", busy, 1'b1);
        c0 = r0_cnt;
        rst_n = 0; m0_req = 0;
        model_reset();
        #1;
        check_all();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_s_addr", s_addr, 32'h0);
        tick();
        tick();
        rst_n = 1;
        tick();
        chk("mid_no_ready", r0_cnt - c0, 0);
        sl_lat = 3;
        e0 = en_cnt; q0 = wd_q.size();
        m0_we = 1; m0_addr = 32'h0200_0010; m0_wdata = 32'h1111_2222;
        m1_we = 1; m1_addr = 32'h0200_0010; m1_wdata = 32'h3333_4444;
        m0_req = 1; m1_req = 1;
        wait_rdy(1, 40);
        chk("post_rst_en_pulses", en_cnt - e0, 2);
        chk("post_rst_first", wd_q[q0], 32'h1111_2222);
        repeat (3) tick();

        // Held request
        drop0 = 0;
        e0 = en_cnt; c0 = r0_cnt;
        m0_we = 0; m0_addr = 32'h0200_0008; m0_req = 1;
        repeat (20) tick();
        chk("held_issues", en_cnt - e0, 4);
        chk("held_readies", r0_cnt - c0, 3);
        m0_req = 0; drop0 = 1;
        repeat (8) tick();
        chk("held_final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

endmodule
